// File: rtl/dmem_responder_pkg.sv
// Shared encodings and helpers for the data-memory responder.
// Alignment helpers serve both builds selected by DMEM_MISALIGN_CHECK_EN.
package dmem_responder_pkg;

    localparam int DMEM_XLEN = 32;

    localparam logic [1:0] DMEM_SIZE_B = 2'b00;
    localparam logic [1:0] DMEM_SIZE_H = 2'b01;
    localparam logic [1:0] DMEM_SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        DMEM_ST_IDLE = 2'd0,
        DMEM_ST_WAIT = 2'd1,
        DMEM_ST_RESP = 2'd2
    } dmem_state_e;

    // Size 2'b11 behaves exactly like a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b11) ? DMEM_SIZE_W : size;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            DMEM_SIZE_H: return lo[0];
            DMEM_SIZE_W: return lo != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            DMEM_SIZE_H: return {lo[1], 1'b0};
            DMEM_SIZE_W: return 2'b00;
            default:     return lo;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response bundle between the pipeline and the responder.
interface dmem_responder_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder_lane_fmt.sv
// Byte-lane formatter: merges store data into the old word and extracts
// sign/zero-extended load values. Purely combinational.
module dmem_lane_fmt
    import dmem_responder_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] old_word,
    input  logic [XLEN-1:0] wdata,
    input  logic [1:0]      addr_lo,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] st_word,
    output logic [XLEN-1:0] ld_word
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b  = old_word[{addr_lo, 3'b000} +: 8];
        lane_h  = old_word[{addr_lo[1], 4'b0000} +: 16];
        st_word = old_word;
        ld_word = old_word;
        case (size)
            DMEM_SIZE_B: begin
                st_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
                ld_word = {{(XLEN-8){lane_b[7] & ~is_unsigned}}, lane_b};
            end
            DMEM_SIZE_H: begin
                st_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
                ld_word = {{(XLEN-16){lane_h[15] & ~is_unsigned}}, lane_h};
            end
            default: begin
                st_word = wdata;
                ld_word = old_word;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, LATENCY-cycle wait, one-cycle response.
// Define DMEM_MISALIGN_CHECK_EN to flag misaligned half/word accesses instead of aligning them.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int XLEN       = DMEM_XLEN,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    dmem_state_e           state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic                  uns_q, uns_d;
    logic [1:0]            size_q, size_d;
    logic [1:0]            lo_q, lo_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;
    logic [XLEN-1:0]       rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [XLEN-1:0]       mem_q [2**DEPTH_LOG2];
    logic [XLEN-1:0]       old_word, st_word, ld_word;
    logic [1:0]            fmt_lo;
    logic                  misal;
    logic                  commit;
    logic                  mem_we;
    logic                  unused_addr_hi;

    // Address bits above the array span wrap around and are deliberately dropped.
    assign unused_addr_hi = ^bus.req_addr[XLEN-1:DEPTH_LOG2+2];
    assign old_word       = mem_q[idx_q];

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misal  = is_misaligned(size_q, lo_q);
    assign fmt_lo = lo_q;
`else
    assign misal  = 1'b0;
    assign fmt_lo = align_lo(size_q, lo_q);
`endif

    dmem_lane_fmt #(.XLEN(XLEN)) u_lane_fmt (
        .old_word    (old_word),
        .wdata       (wdata_q),
        .addr_lo     (fmt_lo),
        .size        (size_q),
        .is_unsigned (uns_q),
        .st_word     (st_word),
        .ld_word     (ld_word)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        uns_d   = uns_q;
        size_d  = size_q;
        lo_d    = lo_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        commit  = 1'b0;
        case (state_q)
            DMEM_ST_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    uns_d   = bus.req_unsigned;
                    size_d  = norm_size(bus.req_size);
                    lo_d    = bus.req_addr[1:0];
                    idx_d   = bus.req_addr[DEPTH_LOG2+1:2];
                    wdata_d = bus.req_wdata;
                    cnt_d   = CNT_INIT;
                    state_d = DMEM_ST_WAIT;
                end
            end
            DMEM_ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    // Store and load both resolve here, so a later load sees this store.
                    commit  = 1'b1;
                    rdata_d = (we_q || misal) ? '0 : ld_word;
                    err_d   = misal;
                    state_d = DMEM_ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DMEM_ST_RESP: state_d = DMEM_ST_IDLE;
            default:      state_d = DMEM_ST_IDLE;
        endcase
    end

    assign mem_we = commit & we_q & ~misal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= DMEM_ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= DMEM_SIZE_B;
            lo_q    <= 2'b00;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            size_q  <= size_d;
            lo_q    <= lo_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[idx_q] <= st_word;
    end

    assign bus.req_ready  = (state_q == DMEM_ST_IDLE);
    assign bus.resp_valid = (state_q == DMEM_ST_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

endmodule
